// File: rtl/gf2_polydiv.sv
// Iterative GF(2)[x] polynomial divider (quotient and remainder), BPC dividend bits per cycle.
// Optional GF2DIV_EARLY_EXIT_EN: finishes in one cycle when deg(A') < deg(B').
module gf2_polydiv #(
    parameter int XLEN = 64,
    parameter int BPC  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Start,
    input  logic            Flush,
    input  logic            W64,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Quot,
    output logic [XLEN-1:0] Rem
);
    localparam int DW = $clog2(XLEN);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] LO32 = XLEN'(64'hFFFF_FFFF);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [XLEN-1:0] r_a, r_b, r_w, r_q;
    logic [DW-1:0]   r_d;
    logic [CW-1:0]   r_cnt;
    logic            r_w64;

    logic            w_w64, w_accept, w_fast;
    logic [XLEN-1:0] w_a, w_b, w_an, w_wn, w_qn;
    logic [DW-1:0]   w_db;
    logic [CW-1:0]   w_n;

    function automatic logic [XLEN-1:0] sx(input logic [XLEN-1:0] v, input logic en);
        sx = v;
        if (en)
            for (int i = 32; i < XLEN; i++) sx[i] = v[31];
    endfunction

    assign w_w64    = (XLEN == 64) && W64;
    assign w_a      = w_w64 ? (A & LO32) : A;
    assign w_b      = w_w64 ? (B & LO32) : B;
    assign w_n      = w_w64 ? CW'(32 / BPC) : CW'(XLEN / BPC);
    assign w_accept = Start && !Flush && (r_state == S_IDLE || r_state == S_DONE);

    always_comb begin
        w_db = '0;
        for (int i = 0; i < XLEN; i++)
            if (w_b[i]) w_db = DW'(i);
    end

`ifdef GF2DIV_EARLY_EXIT_EN
    logic [DW-1:0] w_da;
    always_comb begin
        w_da = '0;
        for (int i = 0; i < XLEN; i++)
            if (w_a[i]) w_da = DW'(i);
    end
    assign w_fast = (w_b == '0) || (w_a == '0) || (w_da < w_db);
`else
    assign w_fast = (w_b == '0);
`endif

    // r_a is left-aligned so the next dividend bit is always the MSB; W stays below 2^d.
    always_comb begin
        w_an = r_a;
        w_wn = r_w;
        w_qn = r_q;
        for (int k = 0; k < BPC; k++) begin
            w_wn = {w_wn[XLEN-2:0], w_an[XLEN-1]};
            w_an = w_an << 1;
            w_qn = w_qn << 1;
            if (w_wn[r_d]) begin
                w_wn    = w_wn ^ r_b;
                w_qn[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        Busy   = (r_state == S_BUSY);
        Done   = (r_state == S_DONE);
        case (r_state)
            S_IDLE, S_DONE: w_next = w_accept ? (w_fast ? S_DONE : S_BUSY) : S_IDLE;
            S_BUSY:         if (r_cnt == CW'(1)) w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
        if (Flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_w   <= '0;
            r_q   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
            r_w64 <= 1'b0;
            Quot  <= '0;
            Rem   <= '0;
        end else if (w_accept) begin
            r_a   <= w_w64 ? (w_a << (XLEN - 32)) : w_a;
            r_b   <= w_b;
            r_d   <= w_db;
            r_w   <= '0;
            r_q   <= '0;
            r_cnt <= w_n;
            r_w64 <= w_w64;
            if (w_fast) begin
                Quot <= '0;
                Rem  <= sx(w_a, w_w64);
            end
        end else if (r_state == S_BUSY && !Flush) begin
            r_a   <= w_an;
            r_w   <= w_wn;
            r_q   <= w_qn;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                Quot <= sx(w_qn, r_w64);
                Rem  <= sx(w_wn, r_w64);
            end
        end else if (Flush) begin
            r_cnt <= '0;
        end
    end
endmodule
